dual_port_sram_arbiter: RTL
===========================

Name: dual_port_sram_arbiter

Overview:
Shares one dual_port_sram instance between NUM_REQ requesters. Each requester has a write channel and a read channel with valid/ready handshakes. Independent round-robin arbiters grant the SRAM write port and read port once per cycle. The block drives registered SRAM control/address/data and routes read data back to the granted requester after the fixed SRAM latency.

Parameters:
WIDTH, 32, data word width
DEPTH, 16, SRAM words
ADDR_WIDTH, $clog2(DEPTH), address width (derived)
NUM_REQ, 2, number of requesters (2..8)
READ_LATENCY, 1, cycles from SRAM read address presented to sram_read_data valid

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-high reset
wr_req_valid  input  NUM_REQ  per-requester write request
wr_req_ready  output  NUM_REQ  write grant, one-hot or zero
wr_req_address  input  NUM_REQ*ADDR_WIDTH  flattened, requester i at slice i
wr_req_data  input  NUM_REQ*WIDTH  flattened write data
rd_req_valid  input  NUM_REQ  per-requester read request
rd_req_ready  output  NUM_REQ  read grant, one-hot or zero
rd_req_address  input  NUM_REQ*ADDR_WIDTH  flattened read addresses
rd_rsp_valid  output  NUM_REQ  one-hot read response strobe
rd_rsp_data  output  WIDTH  read data, valid when any rd_rsp_valid bit set
sram_read_address  output  ADDR_WIDTH  to SRAM
sram_write_address  output  ADDR_WIDTH  to SRAM
sram_write_data  output  WIDTH  to SRAM
sram_chip_select  output  1  to SRAM
sram_write_enable  output  1  to SRAM
sram_output_enable  output  1  to SRAM
sram_read_data  input  WIDTH  from SRAM

Behaviour:
- Reset (async, immediate): all sram_* outputs 0, rd_rsp_valid 0, both round-robin pointers to requester 0, response pipeline cleared. Ready outputs 0 while rst high.
- Grants are combinational from valid and pointer; transfer when valid & ready at a posedge. Valid must stay high with stable address/data until accepted.
- Round-robin: search starts at pointer; after a transfer by requester k, pointer := (k+1) mod NUM_REQ. No transfer -> pointer unchanged. Write and read pointers independent.
- Accept at edge T: sram_write_address/data/enable (write) or sram_read_address/output_enable (read) registered at T, held one cycle; sram_chip_select = write or read active that cycle. Idle cycle: enables 0, addresses/data hold last value.
- Write and read from different requesters, or the same requester, may both transfer in one cycle.
- Hazard: if the winning read address equals the write being accepted the same cycle, or the write registered at the previous edge (still in flight), rd_req_ready is 0 that cycle; read pointer not advanced. Read then returns newly written data.
- Read response: accept at edge T -> rd_rsp_valid[k] high for exactly one cycle, sampled at edge T+1+READ_LATENCY (T+2 at default). rd_rsp_data = sram_read_data combinationally. Requester ID carried in a (1+READ_LATENCY)-deep shift pipeline. Back-to-back reads give back-to-back responses, in order; no response backpressure.
- Reset mid-operation: in-flight reads dropped, no response issued; pending writes not yet registered are lost.
- Addresses >= DEPTH (non-power-of-two DEPTH) pass through unchanged; requester's responsibility.

Test Plan:
- Reset: assert rst mid-cycle with valids high -> all outputs 0 immediately; after release first grant goes to requester 0.
- Single-requester fill: requester 0 writes $random values to addresses 0..15 back-to-back, then reads 0..15 -> one grant per cycle, each rd_rsp_valid[0] at T+2 with matching data, 16 consecutive responses.
- Contention: both requesters hold wr_req_valid for 6 cycles -> grants alternate 0,1,0,1,0,1; same for reads, pointers independent (write on 1 while read on 0 when staggered).
- Simultaneous write+read: req0 writes addr 3 <- 0xDEADBEEF while req1 reads addr 5 (holding 0x12345678) same cycle -> both accepted; req1 gets 0x12345678 at T+2.
- Hazard: write addr 7 <- 0xCAFEF00D and read addr 7 same cycle -> read stalled until write is no longer in flight, then response 0xCAFEF00D; a colliding read at the next cycle is likewise stalled.
- Reset during read: accept read, assert rst at T+1 -> no rd_rsp_valid ever pulses for it.

Source files
------------

// File: rtl/dual_port_sram_arbiter.sv
// Round-robin arbitration of NUM_REQ write and read channels onto one dual-port SRAM,
// with registered SRAM controls and a requester-ID pipeline that routes read data back.
module dual_port_sram_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req_valid,
  output logic [NUM_REQ-1:0]            wr_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_address,
  input  logic [NUM_REQ*WIDTH-1:0]      wr_req_data,
  input  logic [NUM_REQ-1:0]            rd_req_valid,
  output logic [NUM_REQ-1:0]            rd_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_address,
  output logic [NUM_REQ-1:0]            rd_rsp_valid,
  output logic [WIDTH-1:0]              rd_rsp_data,
  output logic [ADDR_WIDTH-1:0]         sram_read_address,
  output logic [ADDR_WIDTH-1:0]         sram_write_address,
  output logic [WIDTH-1:0]              sram_write_data,
  output logic                          sram_chip_select,
  output logic                          sram_write_enable,
  output logic                          sram_output_enable,
  input  logic [WIDTH-1:0]              sram_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] wr_addr_arr [NUM_REQ];
  logic [WIDTH-1:0]      wr_data_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wr_addr_arr[g] = wr_req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_arr[g] = wr_req_data[g*WIDTH +: WIDTH];
    assign rd_addr_arr[g] = rd_req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [IDX_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx, wr_cand, rd_cand;
  logic             wr_found, rd_found;
  logic             rd_hazard, wr_fire, rd_fire;
  logic [NUM_REQ-1:0] rsp_pipe [READ_LATENCY+1];

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    wr_found = 1'b0;
    wr_idx   = '0;
    wr_cand  = '0;
    rd_found = 1'b0;
    rd_idx   = '0;
    rd_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_cand = IDX_W'((int'(wr_ptr) + i) % NUM_REQ);
      if (!wr_found && wr_req_valid[wr_cand]) begin
        wr_found = 1'b1;
        wr_idx   = wr_cand;
      end
      rd_cand = IDX_W'((int'(rd_ptr) + i) % NUM_REQ);
      if (!rd_found && rd_req_valid[rd_cand]) begin
        rd_found = 1'b1;
        rd_idx   = rd_cand;
      end
    end
  end

  // A read may not overtake a write to the same word that is being accepted now
  // or was registered at the previous edge; stalling makes it return the new data.
  assign rd_hazard = rd_found &&
                     ((wr_found && (rd_addr_arr[rd_idx] == wr_addr_arr[wr_idx])) ||
                      (sram_write_enable && (rd_addr_arr[rd_idx] == sram_write_address)));

  assign wr_fire = wr_found && !rst;
  assign rd_fire = rd_found && !rd_hazard && !rst;

  // Handshake: a request transfers at a posedge where valid and ready are both high;
  // the requester keeps valid, address and data stable until then. Ready is one-hot or zero.
  always_comb begin
    wr_req_ready = '0;
    rd_req_ready = '0;
    if (wr_fire) wr_req_ready[wr_idx] = 1'b1;
    if (rd_fire) rd_req_ready[rd_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      sram_read_address  <= '0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
      sram_chip_select   <= 1'b0;
      sram_write_enable  <= 1'b0;
      sram_output_enable <= 1'b0;
      for (int s = 0; s <= READ_LATENCY; s++) rsp_pipe[s] <= '0;
    end else begin
      sram_write_enable  <= wr_fire;
      sram_output_enable <= rd_fire;
      sram_chip_select   <= wr_fire || rd_fire;
      if (wr_fire) begin
        sram_write_address <= wr_addr_arr[wr_idx];
        sram_write_data    <= wr_data_arr[wr_idx];
        wr_ptr             <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      if (rd_fire) begin
        sram_read_address <= rd_addr_arr[rd_idx];
        rd_ptr            <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
      // Stage 0 is loaded with the address; the last stage lines up with SRAM data.
      rsp_pipe[0] <= rd_req_ready;
      for (int s = 1; s <= READ_LATENCY; s++) rsp_pipe[s] <= rsp_pipe[s-1];
    end
  end

  assign rd_rsp_valid = rsp_pipe[READ_LATENCY];
  assign rd_rsp_data  = sram_read_data;

endmodule
